// File: rtl/residual_add_seq_if.sv
//------------------------------------------------------------------------------
// Module      : residual_add_seq_if
// Description : Control, source-read and destination-write signals of the
//               residual adder, bundled with DUT (slave) and driver (master)
//               views.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface residual_add_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 8
);
    // job control
    logic                          start;
    logic [ADDR_WIDTH:0]           len;
    logic                          busy;
    logic                          done;
    logic                          ovf;
    // source buffers A and B share one read port address
    logic                          rd_en;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [LANES*DATA_WIDTH-1:0]   rd_data_a;
    logic [LANES*DATA_WIDTH-1:0]   rd_data_b;
    // destination buffer
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [LANES*DATA_WIDTH-1:0]   wr_data;

    modport slave (
        input  start, len, rd_data_a, rd_data_b,
        output busy, done, ovf, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, len, rd_data_a, rd_data_b,
        input  busy, done, ovf, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/residual_add_seq.sv
//------------------------------------------------------------------------------
// Module      : residual_add_seq
// Description : Streams len words from buffers A and B, adds them lane-wise
//               and writes the sums to a destination buffer.
//               Optional macro RESIDUAL_ADD_SAT_EN: saturate lane sums and
//               raise the sticky ovf flag; otherwise sums wrap, ovf = 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module residual_add_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    residual_add_seq_if.slave  bus
);

    localparam int                  C_WORD_W = LANES * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_ONE    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic                    done_q;
    logic                    busy_q, busy_d;

    logic                    accept_w;
    logic                    rd_en_w;
    logic [ADDR_WIDTH-1:0]   rd_addr_w;
    logic [C_WORD_W-1:0]     sum_w;

    // The done cycle is already IDLE but still reports busy, so a start there
    // must not be taken; the next cycle is the first one that may accept.
    assign accept_w  = (state_q == IDLE) && !done_q && bus.start;
    assign rd_en_w   = (state_q == READ);
    assign rd_addr_w = rd_en_w ? cnt_q[ADDR_WIDTH-1:0] : '0;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    if (bus.len != '0) begin
                        state_d = READ;
                        len_d   = bus.len;
                        cnt_d   = '0;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            READ: begin
                // counter is one bit wider than the address so len = 2^ADDR_WIDTH fits
                if (cnt_q == len_q - C_ONE) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            DRAIN:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (state_q == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= rd_en_w;
            if (rd_en_w) begin
                wr_addr_q <= rd_addr_w;
            end
            done_q    <= (state_q == FIN);
            busy_q    <= busy_d;
        end
    end

`ifdef RESIDUAL_ADD_SAT_EN
    localparam logic [DATA_WIDTH-1:0] C_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] C_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [LANES-1:0] lane_sat_w;
    logic             ovf_q;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_w;
        logic [DATA_WIDTH-1:0] b_w;

        assign a_w = bus.rd_data_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_w = bus.rd_data_b[i*DATA_WIDTH +: DATA_WIDTH];

`ifdef RESIDUAL_ADD_SAT_EN
        logic [DATA_WIDTH:0] ext_w;

        // one guard bit: overflow when it disagrees with the result sign
        assign ext_w         = {a_w[DATA_WIDTH-1], a_w} + {b_w[DATA_WIDTH-1], b_w};
        assign lane_sat_w[i] = ext_w[DATA_WIDTH] ^ ext_w[DATA_WIDTH-1];
        assign sum_w[i*DATA_WIDTH +: DATA_WIDTH] =
            lane_sat_w[i] ? (ext_w[DATA_WIDTH] ? C_SAT_MIN : C_SAT_MAX)
                          : ext_w[DATA_WIDTH-1:0];
`else
        assign sum_w[i*DATA_WIDTH +: DATA_WIDTH] = a_w + b_w;
`endif
    end

`ifdef RESIDUAL_ADD_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept_w) begin
            ovf_q <= 1'b0;
        end else if (wr_en_q && (|lane_sat_w)) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // Source data lands in the write cycle, so the sum is formed there and
    // presented alongside the registered write strobe.
    assign bus.rd_en   = rd_en_w;
    assign bus.rd_addr = rd_addr_w;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_en_q ? sum_w : '0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_residual_add_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_residual_add_seq
// Description : Self-checking bench for residual_add_seq with a behavioural
//               memory and lane-sum reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_residual_add_seq;

    localparam int DW    = 16;
    localparam int LN    = 4;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam longint SMAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (DW - 1));

    logic clk;
    logic rst_n;

    residual_add_seq_if #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW)) bus ();

    residual_add_seq #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [LN*DW-1:0] mem_a [DEPTH];
    logic [LN*DW-1:0] mem_b [DEPTH];

    // synchronous-read source buffers
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem_a[bus.rd_addr];
            bus.rd_data_b <= mem_b[bus.rd_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [LN*DW-1:0] ref_add(input logic [LN*DW-1:0] a,
                                                  input logic [LN*DW-1:0] b,
                                                  output logic sat);
        logic [LN*DW-1:0] r;
        longint sa, sb, s;
        r   = '0;
        sat = 1'b0;
        for (int i = 0; i < LN; i++) begin
            sa = longint'($signed(a[i*DW +: DW]));
            sb = longint'($signed(b[i*DW +: DW]));
            s  = sa + sb;
`ifdef RESIDUAL_ADD_SAT_EN
            if (s > SMAX) begin s = SMAX; sat = 1'b1; end
            else if (s < SMIN) begin s = SMIN; sat = 1'b1; end
`endif
            r[i*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = {$urandom, $urandom};
            mem_b[i] = {$urandom, $urandom};
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {43'd0, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr,
                       bus.busy, bus.done, bus.ovf}, 64'd0);
        check_eq({tag, "_wdata"}, bus.wr_data, 64'd0);
    endtask

    // One job: start in cycle 0, observe every later cycle up to one past done.
    task automatic run_job(input int L, input int extra_rel);
        int  n_wr, n_rd, n_done, done_rel, busy_err, rd_err, exp_done;
        logic exp_ovf, s;
        logic [LN*DW-1:0] exp_d;
        exp_done = (L == 0) ? 2 : L + 3;
        exp_ovf  = 1'b0;
        for (int j = 0; j < L; j++) begin
            exp_d   = ref_add(mem_a[j], mem_b[j], s);
            exp_ovf = exp_ovf | s;
        end
        n_wr = 0; n_rd = 0; n_done = 0; done_rel = -1; busy_err = 0; rd_err = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = L[AW:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= L + 12; k++) begin
            if (bus.rd_en) begin
                if (bus.rd_addr !== n_rd[AW-1:0]) rd_err++;
                n_rd++;
            end
            if (bus.wr_en) begin
                exp_d = ref_add(mem_a[n_wr % DEPTH], mem_b[n_wr % DEPTH], s);
                check_eq("wr_cycle", 64'(k), 64'(n_wr + 2));
                check_eq("wr_addr", 64'(bus.wr_addr), 64'(n_wr % DEPTH));
                check_eq("wr_data", bus.wr_data, exp_d);
                n_wr++;
            end
            if (bus.done) begin
                n_done++;
                done_rel = k;
            end
            if (bus.busy !== (k <= exp_done)) busy_err++;
            if (k == exp_done + 1) break;
            if (k == extra_rel) begin
                bus.start = 1'b1;
                bus.len   = 9'd3;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check_eq("n_writes", 64'(n_wr), 64'(L));
        check_eq("n_reads", 64'(n_rd), 64'(L));
        check_eq("rd_order", 64'(rd_err), 64'd0);
        check_eq("n_done", 64'(n_done), 64'd1);
        check_eq("done_cycle", 64'(done_rel), 64'(exp_done));
        check_eq("busy", 64'(busy_err), 64'd0);
        check_eq("ovf", 64'(bus.ovf), 64'(exp_ovf));
    endtask

    initial begin
        int n_bad, n_wr, L;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // lanes 1 + 2 over three words
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = {LN{16'd1}};
            mem_b[i] = {LN{16'd2}};
        end
        run_job(3, 0);
        run_job(0, 0);

        // signed overflow corner on lane 0
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 64'h0000_0000_0000_7FFF;
        mem_b[0] = 64'h0000_0000_0000_0001;
        run_job(1, 0);

        // second start mid-job is ignored
        fill_random();
        run_job(5, 2);

        // random jobs; some raise a start during the done cycle
        for (int t = 0; t < 6; t++) begin
            fill_random();
            L = $urandom_range(1, 24);
            run_job(L, (t % 2 == 1) ? L + 3 : 0);
        end

        // full address range
        fill_random();
        run_job(DEPTH, 0);

        // reset after the second write of a len=8 job
        fill_random();
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 9'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_wr = 0;
        for (int k = 1; k <= 20 && n_wr < 2; k++) begin
            if (bus.wr_en) n_wr++;
            if (n_wr < 2) begin
                @(posedge clk); #1;
            end
        end
        check_eq("mid_writes_before_rst", 64'(n_wr), 64'd2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        n_bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
            if (bus.wr_en || bus.rd_en || bus.busy || bus.done) n_bad++;
        end
        check_eq("no_activity_after_rst", 64'(n_bad), 64'd0);
        run_job(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
